// File: rtl/spike_rate_encoder_pkg.sv
// spike_rate_encoder_pkg: shared constants, state enum and LFSR step for the rate encoder
package spike_rate_encoder_pkg;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_CH_ADDR_WIDTH = 2;
  localparam int DEF_INTENSITY_WIDTH = 8;
  localparam int DEF_STEP_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} enc_state_e;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? (s >> 1) ^ LFSR_TAPS : s >> 1;
  endfunction
endpackage

// File: rtl/spike_rate_encoder_if.sv
// spike_rate_encoder_if: host memory port, run control and spike bus of the rate encoder
interface spike_rate_encoder_if
  import spike_rate_encoder_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int CH_ADDR_WIDTH = DEF_CH_ADDR_WIDTH,
  parameter int INTENSITY_WIDTH = DEF_INTENSITY_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH
);
  logic [CH_ADDR_WIDTH-1:0] mem_addr;
  logic [INTENSITY_WIDTH-1:0] mem_din;
  logic mem_wen;
  logic [INTENSITY_WIDTH-1:0] mem_dout;
  logic start;
  logic [STEP_WIDTH-1:0] num_steps;
  logic busy;
  logic done;
  logic [STEP_WIDTH-1:0] step_count;
  logic [NUM_CHANNELS-1:0] spike_out;
  modport master (
    output mem_addr, mem_din, mem_wen, start, num_steps,
    input mem_dout, busy, done, step_count, spike_out
  );
  modport slave (
    input mem_addr, mem_din, mem_wen, start, num_steps,
    output mem_dout, busy, done, step_count, spike_out
  );
endinterface

// File: rtl/spike_rate_encoder_lfsr16.sv
// lfsr16: 16-bit Galois LFSR with seed load and advance, exposing its low bits as a sample
module lfsr16
  import spike_rate_encoder_pkg::*;
#(
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [15:0]          seed,
  input  logic                 advance,
  output logic [OUT_WIDTH-1:0] state
);
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = load ? seed : advance ? lfsr_next(lfsr_q) : lfsr_q;
  always_ff @(posedge clk) lfsr_q <= rst ? seed : lfsr_d;
  assign state = lfsr_q[OUT_WIDTH-1:0];
endmodule

// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: Bernoulli rate encoder emitting num_steps spike vectors from per-channel intensities
module spike_rate_encoder
  import spike_rate_encoder_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int CH_ADDR_WIDTH = DEF_CH_ADDR_WIDTH,
  parameter int INTENSITY_WIDTH = DEF_INTENSITY_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic clk,
  input logic rst,
  spike_rate_encoder_if.slave bus
);
  enc_state_e state_q, state_d;
  logic [STEP_WIDTH-1:0] n_q, n_d, step_q, step_d;
  logic [NUM_CHANNELS-1:0] spike_q, spike_d, hit;
  logic done_q, done_d, load, adv;
  logic [INTENSITY_WIDTH-1:0] dout_q, dout_d;
  logic [INTENSITY_WIDTH-1:0] inten_q [NUM_CHANNELS];
  logic [INTENSITY_WIDTH-1:0] inten_d [NUM_CHANNELS];
  logic [INTENSITY_WIDTH-1:0] sample [NUM_CHANNELS];
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    lfsr16 #(.OUT_WIDTH(INTENSITY_WIDTH)) u_lfsr (
      .clk(clk), .rst(rst), .load(load), .seed(SEED + 16'(g)),
      .advance(adv), .state(sample[g])
    );
    assign hit[g] = (inten_q[g] == '1) | (sample[g] < inten_q[g]);
  end
  always_comb begin
    load = (state_q == IDLE) && bus.start;
    adv = state_q == RUN;
    state_d = state_q;
    n_d = n_q;
    step_d = step_q;
    spike_d = '0;
    done_d = 1'b0;
    if (load) begin
      n_d = bus.num_steps;
      step_d = '0;
      state_d = (bus.num_steps == '0) ? DONE : RUN;
    end else if (adv) begin
      spike_d = hit;
      step_d = step_q + STEP_WIDTH'(1);
      state_d = (step_q + STEP_WIDTH'(1) == n_q) ? DONE : RUN;
    end else if (state_q == DONE) begin
      done_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_comb begin
    dout_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      inten_d[i] = (bus.mem_wen && int'(bus.mem_addr) == i) ? bus.mem_din : inten_q[i];
      dout_d = (int'(bus.mem_addr) == i) ? inten_q[i] : dout_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      step_q <= '0;
      spike_q <= '0;
      done_q <= 1'b0;
      dout_q <= '0;
      inten_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      step_q <= step_d;
      spike_q <= spike_d;
      done_q <= done_d;
      dout_q <= dout_d;
      inten_q <= inten_d;
    end
  end
  assign bus.mem_dout = dout_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.step_count = step_q;
  assign bus.spike_out = spike_q;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb_spike_rate_encoder: directed and randomized checks of the rate encoder against a behavioural model
module tb_spike_rate_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  spike_rate_encoder_if #(.NUM_CHANNELS(4), .CH_ADDR_WIDTH(2), .INTENSITY_WIDTH(8), .STEP_WIDTH(16)) bus ();
  spike_rate_encoder dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  int inten_m [4];
  logic [3:0] train [$];
  logic [3:0] prev [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write(input int a, input int d);
    bus.mem_addr = 2'(a);
    bus.mem_din = 8'(d);
    bus.mem_wen = 1'b1;
    tick();
    bus.mem_wen = 1'b0;
    inten_m[a] = d;
  endtask

  function automatic int lfsr_step(input int s);
    return (s % 2 == 1) ? ((s / 2) ^ 'hB400) : s / 2;
  endfunction

  task automatic run(input int n, input bit hold);
    int l [4];
    int busy_cycles;
    logic [3:0] e;
    busy_cycles = 0;
    for (int c = 0; c < 4; c++) l[c] = 'hACE1 + c;
    train.delete();
    bus.num_steps = 16'(n);
    bus.start = 1'b1;
    tick();
    if (!hold) bus.start = 1'b0;
    chk("e0_spike", 32'(bus.spike_out), 0);
    chk("e0_step", 32'(bus.step_count), 0);
    busy_cycles += int'(bus.busy);
    for (int k = 1; k <= n; k++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        e[c] = (inten_m[c] == 255) || ((l[c] % 256) < inten_m[c]);
        l[c] = lfsr_step(l[c]);
      end
      chk("step_spike", 32'(bus.spike_out), 32'(e));
      chk("step_count", 32'(bus.step_count), k);
      chk("step_done", 32'(bus.done), 0);
      busy_cycles += int'(bus.busy);
      train.push_back(bus.spike_out);
    end
    bus.start = 1'b0;
    tick();
    chk("end_done", 32'(bus.done), 1);
    chk("end_spike", 32'(bus.spike_out), 0);
    chk("end_busy", 32'(bus.busy), 0);
    chk("end_step", 32'(bus.step_count), n);
    chk("busy_cycles", busy_cycles, n + 1);
    tick();
    chk("done_pulse", 32'(bus.done), 0);
    chk("idle_step", 32'(bus.step_count), n);
  endtask

  function automatic int ones(input int ch);
    int s = 0;
    foreach (train[i]) s += int'(train[i][ch]);
    return s;
  endfunction

  initial begin
    rst = 1'b1;
    bus.mem_addr = '0;
    bus.mem_din = '0;
    bus.mem_wen = 1'b0;
    bus.start = 1'b0;
    bus.num_steps = '0;
    for (int c = 0; c < 4; c++) inten_m[c] = 0;
    tick();
    tick();
    chk("rst_spike", 32'(bus.spike_out), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_step", 32'(bus.step_count), 0);
    chk("rst_dout", 32'(bus.mem_dout), 0);
    rst = 1'b0;
    write(0, 255);
    write(1, 0);
    write(2, 10);
    write(3, 200);
    for (int c = 0; c < 4; c++) begin
      bus.mem_addr = 2'(c);
      tick();
      chk("readback", 32'(bus.mem_dout), inten_m[c]);
    end
    bus.mem_addr = 2'd2;
    bus.mem_din = 8'd77;
    bus.mem_wen = 1'b1;
    tick();
    bus.mem_wen = 1'b0;
    chk("rbw_old", 32'(bus.mem_dout), 10);
    tick();
    chk("rbw_new", 32'(bus.mem_dout), 77);
    write(2, 10);
    run(10, 1'b0);
    chk("ch0_all", ones(0), 10);
    chk("ch1_none", ones(1), 0);
    prev = train;
    run(10, 1'b1);
    foreach (prev[i]) chk("repeat_train", 32'(train[i]), 32'(prev[i]));
    write(0, 128);
    run(1000, 1'b0);
    chk("rate_128", 32'((ones(0) >= 440) && (ones(0) <= 560)), 1);
    for (int r = 0; r < 3; r++) begin
      int n;
      for (int c = 0; c < 4; c++) write(c, int'($urandom_range(0, 255)));
      n = int'($urandom_range(1, 40));
      run(n, r[0]);
      prev = train;
      run(n, 1'b0);
      foreach (prev[i]) chk("rand_repeat", 32'(train[i]), 32'(prev[i]));
    end
    run(0, 1'b0);
    write(0, 255);
    bus.num_steps = 16'd20;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_spike", 32'(bus.spike_out), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    tick();
    chk("abort_nodone", 32'(bus.done), 0);
    for (int c = 0; c < 4; c++) begin
      inten_m[c] = 0;
      bus.mem_addr = 2'(c);
      tick();
      chk("abort_inten", 32'(bus.mem_dout), inten_m[c]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
